pulse_pattern_seq: RTL and testbench

- Programmable sequencer directly upstream of the pulse generator. It drives the generator's length1 (high duration) and length2 (low duration) from a small table of (high, low) pairs.
- It advances to the next table entry on each falling edge of the generator's pulse output, and holds the generator in reset while idle.
- Used for multi-rate blink patterns (cursor, attribute blink) in the glyph display path.

---
 rtl/pulse_pattern_seq.sv | 143 ++++++++++++++
 tb/tb_pulse_pattern_seq.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/pulse_pattern_seq.sv
// Pattern sequencer feeding the pulse generator's high/low lengths from a small
// (high, low) table, advancing on each falling edge of the generator output.
module pulse_pattern_seq #(
  parameter int DEPTH = 8,
  parameter int IDX_W = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_addr,
  input  logic [31:0]      wr_high,
  input  logic [31:0]      wr_low,
  input  logic [IDX_W:0]   num_entries,
  input  logic [7:0]       loops,
  input  logic             start,
  input  logic             stop,
  input  logic             pulse_in,
  output logic [31:0]      length1,
  output logic [31:0]      length2,
  output logic             pulse_reset,
  output logic             busy,
  output logic             done,
  output logic [IDX_W-1:0] cur_index
);

  typedef enum logic {IDLE, RUN} state_e;

  localparam logic [IDX_W:0] DEPTH_N = (IDX_W+1)'(DEPTH);

  state_e           state_q, state_d;
  logic [IDX_W:0]   num_q, num_d;
  logic [7:0]       loops_q, loops_d;
  logic [7:0]       cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [31:0]      len1_q, len1_d;
  logic [31:0]      len2_q, len2_d;
  logic             pulse_d_q, pulse_d_d;
  logic             done_q, done_d;

  logic [63:0]      tbl_q [DEPTH];
  logic             fall;
  logic             load;
  logic             start_ok;
  logic [IDX_W:0]   last_idx;

  // NOTE: the table has no reset; its contents are don't-care until written,
  // so it can map onto plain RAM/flops without a reset tree.
  always_ff @(posedge clk) begin
    if (state_q == IDLE && wr_en) tbl_q[wr_addr] <= {wr_high, wr_low};
  end

  assign fall     = pulse_d_q & ~pulse_in;
  assign start_ok = (num_entries != '0) && (num_entries <= DEPTH_N);
  assign last_idx = num_q - (IDX_W+1)'(1);

  // NOTE: combinational logic uses blocking '=' with every output defaulted
  // first, so no latch is inferred and later reads see earlier writes.
  always_comb begin
    state_d   = state_q;
    num_d     = num_q;
    loops_d   = loops_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    len1_d    = len1_q;
    len2_d    = len2_q;
    pulse_d_d = 1'b0;
    done_d    = 1'b0;
    load      = 1'b0;

    case (state_q)
      IDLE: begin
        if (start && !stop && start_ok) begin
          state_d = RUN;
          num_d   = num_entries;
          loops_d = loops;
          cnt_d   = '0;
          idx_d   = '0;
          load    = 1'b1;
        end
      end
      RUN: begin
        pulse_d_d = pulse_in;
        if (stop) begin
          state_d   = IDLE;
          pulse_d_d = 1'b0;
        end else if (fall) begin
          if ({1'b0, idx_q} == last_idx) begin
            idx_d = '0;
            if (loops_q != 8'd0 && cnt_q == loops_q - 8'd1) begin
              state_d   = IDLE;
              done_d    = 1'b1;
              pulse_d_d = 1'b0;
            end else begin
              cnt_d = cnt_q + 8'd1;
              load  = 1'b1;
            end
          end else begin
            idx_d = idx_q + IDX_W'(1);
            load  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (load) {len1_d, len2_d} = tbl_q[idx_d];
  end

  // NOTE: sequential state uses non-blocking '<=' so all registers update
  // together from pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      num_q     <= '0;
      loops_q   <= '0;
      cnt_q     <= '0;
      idx_q     <= '0;
      len1_q    <= '0;
      len2_q    <= '0;
      pulse_d_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      num_q     <= num_d;
      loops_q   <= loops_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      len1_q    <= len1_d;
      len2_q    <= len2_d;
      pulse_d_q <= pulse_d_d;
      done_q    <= done_d;
    end
  end

  // Decoded from the state register so reset forces the generator into reset at once.
  assign pulse_reset = (state_q == IDLE);
  assign busy        = (state_q == RUN);
  assign done        = done_q;
  assign cur_index   = idx_q;
  assign length1     = len1_q;
  assign length2     = len2_q;

endmodule

// File: tb/tb_pulse_pattern_seq.sv
// Directed self-checking bench for pulse_pattern_seq; pulse_in is driven
// directly so every fall is placed on a known clock edge.
module tb_pulse_pattern_seq;

  localparam int DEPTH = 8;
  localparam int IDX_W = 3;

  logic             clk = 1'b0;
  logic             reset;
  logic             wr_en;
  logic [IDX_W-1:0] wr_addr;
  logic [31:0]      wr_high;
  logic [31:0]      wr_low;
  logic [IDX_W:0]   num_entries;
  logic [7:0]       loops;
  logic             start;
  logic             stop;
  logic             pulse_in;
  logic [31:0]      length1;
  logic [31:0]      length2;
  logic             pulse_reset;
  logic             busy;
  logic             done;
  logic [IDX_W-1:0] cur_index;

  int checks   = 0;
  int failures = 0;

  logic [31:0] exp_hi [3];
  logic [31:0] exp_lo [3];

  pulse_pattern_seq #(.DEPTH(DEPTH), .IDX_W(IDX_W)) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_high(wr_high), .wr_low(wr_low), .num_entries(num_entries),
    .loops(loops), .start(start), .stop(stop), .pulse_in(pulse_in),
    .length1(length1), .length2(length2), .pulse_reset(pulse_reset),
    .busy(busy), .done(done), .cur_index(cur_index)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_entry(input int addr, input int hi, input int lo);
    wr_en   = 1'b1;
    wr_addr = IDX_W'(addr);
    wr_high = 32'(hi);
    wr_low  = 32'(lo);
    tick();
    wr_en = 1'b0;
  endtask

  task automatic do_start(input int n, input int lp);
    num_entries = (IDX_W+1)'(n);
    loops       = 8'(lp);
    start       = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic do_fall();
    pulse_in = 1'b1;
    tick();
    pulse_in = 1'b0;
    tick();
  endtask

  initial begin
    reset = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_high = '0; wr_low = '0;
    num_entries = '0; loops = '0; start = 1'b0; stop = 1'b0; pulse_in = 1'b0;
    exp_hi[0] = 32'd2; exp_lo[0] = 32'd3;
    exp_hi[1] = 32'd4; exp_lo[1] = 32'd1;
    exp_hi[2] = 32'd7; exp_lo[2] = 32'd6;
    #12;
    check("rst_len1", length1, 0);
    check("rst_len2", length2, 0);
    check("rst_preset", pulse_reset, 1);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_idx", cur_index, 0);
    reset = 1'b0;
    tick();

    for (int i = 0; i < 3; i++) write_entry(i, int'(exp_hi[i]), int'(exp_lo[i]));

    // Two entries, one lap: done after the second fall, lengths hold.
    do_start(2, 1);
    check("s1_busy", busy, 1);
    check("s1_preset", pulse_reset, 0);
    check("s1_idx", cur_index, 0);
    check("s1_len1", length1, 2);
    check("s1_len2", length2, 3);
    do_fall();
    check("f1_idx", cur_index, 1);
    check("f1_len1", length1, 4);
    check("f1_len2", length2, 1);
    check("f1_done", done, 0);
    do_fall();
    check("end_done", done, 1);
    check("end_busy", busy, 0);
    check("end_preset", pulse_reset, 1);
    check("end_idx", cur_index, 0);
    check("end_len1", length1, 4);
    check("end_len2", length2, 1);
    tick();
    check("end_done_pulse", done, 0);

    // Endless three-entry pattern, with a dropped table write mid-run.
    do_start(3, 0);
    write_entry(0, 9, 9);
    for (int k = 1; k <= 10; k++) begin
      do_fall();
      check($sformatf("inf_idx%0d", k), cur_index, 32'(k % 3));
      check($sformatf("inf_len1_%0d", k), length1, exp_hi[k % 3]);
      check($sformatf("inf_len2_%0d", k), length2, exp_lo[k % 3]);
      check($sformatf("inf_done%0d", k), done, 0);
      check($sformatf("inf_busy%0d", k), busy, 1);
    end
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check("stop_preset", pulse_reset, 1);
    check("stop_busy", busy, 0);
    check("stop_done", done, 0);

    // Invalid starts and start+stop collision.
    do_start(0, 1);
    check("n0_busy", busy, 0);
    check("n0_preset", pulse_reset, 1);
    do_start(DEPTH + 1, 1);
    check("n9_busy", busy, 0);
    check("n9_preset", pulse_reset, 1);
    stop = 1'b1;
    do_start(2, 1);
    stop = 1'b0;
    check("ss_busy", busy, 0);
    check("ss_preset", pulse_reset, 1);

    // Single entry, two laps: every fall wraps.
    do_start(1, 2);
    do_fall();
    check("one_f1_busy", busy, 1);
    check("one_f1_done", done, 0);
    check("one_f1_idx", cur_index, 0);
    do_fall();
    check("one_f2_done", done, 1);
    check("one_f2_busy", busy, 0);

    // Stop coinciding with a fall wins; index is not advanced.
    do_start(3, 0);
    do_fall();
    check("sf_pre_idx", cur_index, 1);
    pulse_in = 1'b1;
    tick();
    pulse_in = 1'b0;
    stop     = 1'b1;
    tick();
    stop = 1'b0;
    check("sf_busy", busy, 0);
    check("sf_idx", cur_index, 1);
    check("sf_done", done, 0);
    check("sf_preset", pulse_reset, 1);

    // Asynchronous reset between edges, then a clean restart.
    do_start(3, 0);
    do_fall();
    check("ar_pre_idx", cur_index, 1);
    #2;
    reset = 1'b1;
    #1;
    check("ar_preset", pulse_reset, 1);
    check("ar_busy", busy, 0);
    check("ar_len1", length1, 0);
    check("ar_len2", length2, 0);
    check("ar_idx", cur_index, 0);
    #3;
    reset = 1'b0;
    tick();
    do_start(3, 0);
    check("rs_busy", busy, 1);
    check("rs_idx", cur_index, 0);
    check("rs_len1", length1, 2);
    check("rs_len2", length2, 3);
    do_fall();
    check("rs_f_idx", cur_index, 1);
    check("rs_f_len1", length1, 4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
